// File: rtl/sequential_multiplier.sv
// Sequential shift-and-add multiplier on operand magnitudes.
// Signs are captured separately so a downstream stage can apply them;
// product is always an unsigned magnitude with its msb clear.
module sequential_multiplier #(
  parameter int DW   = 8,
  parameter int DW_2 = 2*DW
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [DW-1:0]   multiplier,
  input  logic [DW-1:0]   multiplicand,
  output logic [DW_2-1:0] product,
  output logic            multiplier_msb,
  output logic            multiplicand_msb,
  output logic            busy,
  output logic            ready
);

  localparam int CW = $clog2(DW) + 1;

  typedef enum logic [1:0] {IDLE, MULT, DONE} state_t;

  state_t            r_state, w_state_nxt;
  logic [DW-1:0]     r_a;
  logic [DW_2-1:0]   r_b;
  logic [DW_2-1:0]   r_acc;
  logic [CW-1:0]     r_cnt;
  logic [DW_2-1:0]   r_product;
  logic              r_a_msb, r_b_msb;

  logic [DW-1:0]     w_mag_a, w_mag_b;
  logic [DW_2-1:0]   w_acc_nxt;
  logic              w_last;

  // Two's-complement negation of the most negative value wraps to itself,
  // which read as unsigned is exactly 2^(DW-1): no extra bit needed.
  assign w_mag_a   = multiplier[DW-1]   ? (DW'(0) - multiplier)   : multiplier;
  assign w_mag_b   = multiplicand[DW-1] ? (DW'(0) - multiplicand) : multiplicand;
  assign w_acc_nxt = r_acc + (r_a[0] ? r_b : '0);
  assign w_last    = (r_cnt == CW'(DW-1));

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_state_nxt;
  end

  // Next-state and status outputs
  always_comb begin
    w_state_nxt = r_state;
    busy        = 1'b0;
    ready       = 1'b0;
    case (r_state)
      IDLE: if (start) w_state_nxt = MULT;
      MULT: begin
        busy = 1'b1;
        if (w_last) w_state_nxt = DONE;
      end
      DONE: begin
        busy        = 1'b1;
        ready       = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Datapath: operand capture in IDLE, one shift-add iteration per MULT cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_a       <= '0;
      r_b       <= '0;
      r_acc     <= '0;
      r_cnt     <= '0;
      r_product <= '0;
      r_a_msb   <= 1'b0;
      r_b_msb   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (start) begin
          r_a_msb <= multiplier[DW-1];
          r_b_msb <= multiplicand[DW-1];
          r_a     <= w_mag_a;
          r_b     <= DW_2'(w_mag_b);
          r_acc   <= '0;
          r_cnt   <= '0;
        end
        MULT: begin
          r_acc <= w_acc_nxt;
          r_a   <= r_a >> 1;
          r_b   <= r_b << 1;
          r_cnt <= r_cnt + CW'(1);
          // final partial product folded in directly so DONE shows it
          if (w_last) r_product <= w_acc_nxt;
        end
        default: ;
      endcase
    end
  end

  assign product          = r_product;
  assign multiplier_msb   = r_a_msb;
  assign multiplicand_msb = r_b_msb;

endmodule

// File: tb/tb_sequential_multiplier.sv
// Randomized self-checking bench for sequential_multiplier (DW=8).
module tb_sequential_multiplier;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  multiplier = '0;
  logic [7:0]  multiplicand = '0;
  logic [15:0] product;
  logic        multiplier_msb, multiplicand_msb, busy, ready;

  int n_chk = 0;
  int n_err = 0;

  sequential_multiplier #(.DW(8), .DW_2(16)) dut (
    .clk(clk), .rst(rst), .start(start),
    .multiplier(multiplier), .multiplicand(multiplicand),
    .product(product), .multiplier_msb(multiplier_msb),
    .multiplicand_msb(multiplicand_msb), .busy(busy), .ready(ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // reference: magnitude of an 8-bit two's-complement value
  function automatic int mag(input logic [7:0] v);
    return v[7] ? 256 - int'(v) : int'(v);
  endfunction

  // One full operation: accept, optional mid-MULT start re-pulse, check
  // timing of busy/ready and the final result, then one idle cycle.
  task automatic do_op(input logic [7:0] a, input logic [7:0] b, input bit repulse);
    int exp_p;
    int sres;
    exp_p = mag(a) * mag(b);
    @(negedge clk);
    multiplier = a; multiplicand = b; start = 1'b1;
    @(posedge clk);             // accepting edge
    @(negedge clk);
    start = 1'b0;
    multiplier = 8'($urandom); multiplicand = 8'($urandom);
    chk("msbA_acc", multiplier_msb, a[7]);
    chk("msbB_acc", multiplicand_msb, b[7]);
    chk("busy_k0", busy, 1);
    chk("rdy_k0", ready, 0);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (repulse && k == 3) begin
        start = 1'b1; multiplier = 8'h55; multiplicand = 8'h77;
      end
      if (repulse && k == 4) start = 1'b0;
      chk("busy_k", busy, 1);
      chk("rdy_k", ready, (k == 8) ? 1 : 0);
    end
    chk("product", product, exp_p);
    chk("prod_msb0", product[15], 0);
    chk("msbA", multiplier_msb, a[7]);
    chk("msbB", multiplicand_msb, b[7]);
    // apply signs as the downstream complement stage would
    sres = (multiplier_msb ^ multiplicand_msb) ? -int'(product) : int'(product);
    chk("signed_res", sres, $signed(a) * $signed(b));
    @(negedge clk);
    chk("busy_idle", busy, 0);
    chk("rdy_idle", ready, 0);
    chk("prod_hold", product, exp_p);
  endtask

  initial begin
    logic [7:0] qa [3];
    logic [7:0] qb [3];
    int op;
    bit bad;

    // asynchronous reset state, no clock edge yet
    #1;
    chk("rst_prod", product, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rdy", ready, 0);
    chk("rst_msbs", {multiplier_msb, multiplicand_msb}, 0);
    @(negedge clk); rst = 1'b1;

    do_op(8'd3,   8'd5,   1'b0);
    do_op(8'hFD,  8'd5,   1'b0);
    do_op(8'h80,  8'h80,  1'b0);
    do_op(8'h7F,  8'h80,  1'b0);
    do_op(8'h00,  8'hFF,  1'b0);
    do_op(8'd9,   8'hF7,  1'b1);   // re-pulse mid-MULT must be ignored
    for (int i = 0; i < 20; i++)
      do_op(8'($urandom), 8'($urandom), ($urandom_range(0, 1) == 1));

    // reset at iteration 4 aborts the operation with no ready pulse
    @(negedge clk);
    multiplier = 8'd11; multiplicand = 8'd13; start = 1'b1;
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("abort_prod", product, 0);
    chk("abort_busy", busy, 0);
    chk("abort_rdy", ready, 0);
    chk("abort_msbs", {multiplier_msb, multiplicand_msb}, 0);
    bad = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (ready !== 1'b0 || busy !== 1'b0) bad = 1'b1;
    end
    chk("abort_quiet", bad, 0);
    rst = 1'b1;
    do_op(8'd7, 8'd6, 1'b0);

    // start held high: back-to-back operations, results 10 edges apart
    for (int i = 0; i < 3; i++) begin
      qa[i] = 8'($urandom); qb[i] = 8'($urandom);
    end
    @(negedge clk);
    multiplier = qa[0]; multiplicand = qb[0]; start = 1'b1;
    op = 0;
    @(posedge clk);              // accept of op 0 is edge t=0
    for (int t = 0; t <= 28; t++) begin
      if (t > 0) @(posedge clk);
      @(negedge clk);
      if (t % 10 == 0 && t / 10 + 1 < 3) begin
        multiplier = qa[t / 10 + 1]; multiplicand = qb[t / 10 + 1];
      end
      if (t == 20) start = 1'b0;
      chk("b2b_rdy", ready, (t % 10 == 8) ? 1 : 0);
      if (t % 10 == 8) begin
        chk("b2b_prod", product, mag(qa[op]) * mag(qb[op]));
        chk("b2b_msbs", {multiplier_msb, multiplicand_msb}, {qa[op][7], qb[op][7]});
        op++;
      end
    end
    // start was dropped: no fourth operation
    repeat (2) @(negedge clk);
    chk("b2b_stop", busy, 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
